cls_rx: RTL and testbench



---
 rtl/cls_pkg.sv | 35 +++
 rtl/spi_slave_rx.sv | 116 +++++++++++
 rtl/cls_rx.sv | 168 ++++++++++++++++
 tb/tb_cls_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cls_pkg.sv
// Shared types and constants for the character-LCD receiver model.
// Build option: CLS_RX_ECHO_EN enables the MISO echo of the previous byte.
package cls_pkg;

  localparam int ROWS  = 2;
  localparam int COLS  = 16;
  localparam int NCELL = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ESC,
    S_CSI
  } dec_state_t;

  localparam logic [7:0] ESC      = 8'h1B;
  localparam logic [7:0] LBRACKET = 8'h5B;
  localparam logic [7:0] SEMI     = 8'h3B;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] F_CUP    = 8'h48;
  localparam logic [7:0] F_CLR    = 8'h6A;
  localparam logic [7:0] F_EN     = 8'h65;
  localparam logic [7:0] F_CUR    = 8'h63;
  localparam logic [7:0] F_DISP   = 8'h68;

  // Decimal accumulate, saturating at 255.
  function automatic logic [7:0] p_acc(
    input logic [7:0] p,
    input logic [7:0] c
  );
    logic [11:0] v;
    v = 12'(p) * 12'd10 + 12'(c[3:0]);
    return (v > 12'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/spi_slave_rx.sv
// Mode-3 SPI slave deserialiser with framing-error detect.
// Build option: CLS_RX_ECHO_EN drives MISO with the previous byte.
module spi_slave_rx
  import cls_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_ss,
  input  logic       i_sclk,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_err
);

  logic [2:0] r_ss;
  logic [2:0] r_sclk;
  logic [1:0] r_mosi;
  logic [2:0] r_cnt;
  logic [6:0] r_sh;
  logic       r_valid;
  logic [7:0] r_data;
  logic       r_err;

  logic w_ss_fall;
  logic w_ss_rise;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_bit;
  logic w_done;

  assign w_ss_fall  = r_ss[2] & ~r_ss[1];
  assign w_ss_rise  = ~r_ss[2] & r_ss[1];
  assign w_sck_rise = ~r_sclk[2] & r_sclk[1] & ~r_ss[1];
  assign w_sck_fall = r_sclk[2] & ~r_sclk[1] & ~r_ss[1];
  assign w_bit      = r_mosi[1];
  assign w_done     = w_sck_rise && (r_cnt == 3'd7);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ss   <= 3'b111;
      r_sclk <= 3'b111;
      r_mosi <= 2'b00;
    end else begin
      r_ss   <= {r_ss[1:0], i_ss};
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 3'd0;
      r_sh    <= 7'd0;
      r_valid <= 1'b0;
      r_data  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_ss_fall) begin
        r_cnt <= 3'd0;
      end else if (w_ss_rise) begin
        // Count wraps at 8, so nonzero here means a partial byte.
        r_err <= (r_cnt != 3'd0);
        r_cnt <= 3'd0;
      end else if (w_sck_rise) begin
        r_sh  <= {r_sh[5:0], w_bit};
        r_cnt <= r_cnt + 3'd1;
        if (w_done) begin
          r_valid <= 1'b1;
          r_data  <= {r_sh, w_bit};
        end
      end
    end
  end

`ifdef CLS_RX_ECHO_EN
  logic [7:0] r_last;
  logic [7:0] r_tx;
  logic       r_load;

  // Reload at the first falling edge of each byte; shift on the rest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 8'd0;
      r_tx   <= 8'hFF;
      r_load <= 1'b1;
    end else begin
      if (w_done) begin
        r_last <= {r_sh, w_bit};
        r_load <= 1'b1;
      end else if (w_ss_fall) begin
        r_load <= 1'b1;
      end else if (w_sck_fall) begin
        if (r_load) begin
          r_tx   <= r_last;
          r_load <= 1'b0;
        end else begin
          r_tx <= {r_tx[6:0], 1'b1};
        end
      end
    end
  end

  assign o_miso = r_ss[1] ? 1'b1 : r_tx[7];
`else
  assign o_miso = 1'b1;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;

endmodule

// File: rtl/cls_rx.sv
// Character-LCD link receiver: escape decoder, cursor and 2x16 buffer.
// Build option: CLS_RX_ECHO_EN (see spi_slave_rx).
module cls_rx
  import cls_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cur_row,
  output logic [3:0] cur_col,
  output logic       display_on,
  output logic       backlight,
  output logic [1:0] cursor_mode,
  output logic [1:0] disp_mode,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err
);

  logic       w_bv;
  logic [7:0] w_bd;
  logic       w_ferr;
  logic       w_digit;
  logic       w_print;
  logic [4:0] w_wa;

  dec_state_t r_st;
  logic [7:0] r_p0;
  logic [7:0] r_p1;
  logic       r_pidx;
  logic       r_row;
  logic [3:0] r_col;
  logic       r_on;
  logic       r_bl;
  logic [1:0] r_cm;
  logic [1:0] r_dm;
  logic       r_derr;
  logic [7:0] r_buf [NCELL];
  logic [7:0] r_rd;

  spi_slave_rx u_spi (
    .clock   (clock),
    .reset_n (reset_n),
    .i_ss    (ss),
    .i_sclk  (sclk),
    .i_mosi  (mosi),
    .o_miso  (miso),
    .o_valid (w_bv),
    .o_data  (w_bd),
    .o_err   (w_ferr)
  );

  assign w_digit = (w_bd >= 8'h30) && (w_bd <= 8'h39);
  assign w_print = (w_bd >= 8'h20) && (w_bd <= 8'h7E);
  assign w_wa    = {r_row, r_col};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= S_IDLE;
      r_p0   <= 8'd0;
      r_p1   <= 8'd0;
      r_pidx <= 1'b0;
      r_row  <= 1'b0;
      r_col  <= 4'd0;
      r_on   <= 1'b0;
      r_bl   <= 1'b0;
      r_cm   <= 2'd0;
      r_dm   <= 2'd0;
      r_derr <= 1'b0;
      for (int i = 0; i < NCELL; i++) r_buf[i] <= SPACE;
    end else begin
      r_derr <= 1'b0;
      if (w_bv) begin
        case (r_st)
          S_IDLE: begin
            if (w_bd == ESC) begin
              r_st <= S_ESC;
            end else if (w_print) begin
              r_buf[w_wa] <= w_bd;
              if (r_col == 4'(COLS - 1)) begin
                r_col <= 4'd0;
                r_row <= ~r_row;
              end else begin
                r_col <= r_col + 4'd1;
              end
            end
          end
          S_ESC: begin
            if (w_bd == LBRACKET) begin
              r_st   <= S_CSI;
              r_p0   <= 8'd0;
              r_p1   <= 8'd0;
              r_pidx <= 1'b0;
            end else begin
              r_st   <= S_IDLE;
              r_derr <= 1'b1;
            end
          end
          S_CSI: begin
            unique case (1'b1)
              w_digit: begin
                if (r_pidx) r_p1 <= p_acc(r_p1, w_bd);
                else        r_p0 <= p_acc(r_p0, w_bd);
              end
              (w_bd == SEMI): begin
                if (r_pidx) begin
                  r_st   <= S_IDLE;
                  r_derr <= 1'b1;
                end else begin
                  r_pidx <= 1'b1;
                end
              end
              default: begin
                r_st <= S_IDLE;
                unique case (1'b1)
                  (w_bd == F_CUP): begin
                    r_row <= (r_p0 > 8'(ROWS - 1)) ? 1'(ROWS - 1) : r_p0[0];
                    r_col <= (r_p1 > 8'(COLS - 1)) ? 4'(COLS - 1) : r_p1[3:0];
                  end
                  (w_bd == F_CLR): begin
                    if (r_p0 == 8'd0) begin
                      for (int i = 0; i < NCELL; i++) r_buf[i] <= SPACE;
                      r_row <= 1'b0;
                      r_col <= 4'd0;
                    end else begin
                      r_derr <= 1'b1;
                    end
                  end
                  (w_bd == F_EN): begin
                    r_on <= r_p0[0];
                    r_bl <= r_p0[1];
                  end
                  (w_bd == F_CUR):  r_cm <= r_p0[1:0];
                  (w_bd == F_DISP): r_dm <= r_p0[1:0];
                  default:          r_derr <= 1'b1;
                endcase
              end
            endcase
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  // Registered read; a same-cycle write returns the old value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rd <= 8'd0;
    else          r_rd <= r_buf[rd_addr];
  end

  assign rd_data     = r_rd;
  assign cur_row     = r_row;
  assign cur_col     = r_col;
  assign display_on  = r_on;
  assign backlight   = r_bl;
  assign cursor_mode = r_cm;
  assign disp_mode   = r_dm;
  assign byte_valid  = w_bv;
  assign byte_data   = w_bd;
  assign err         = w_ferr | r_derr;

endmodule

// File: tb/tb_cls_rx.sv
// Directed bench for cls_rx: vector table plus framing, wrap and clear
// sequences.
module tb_cls_rx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       cur_row;
  logic [3:0] cur_col;
  logic       display_on;
  logic       backlight;
  logic [1:0] cursor_mode;
  logic [1:0] disp_mode;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int bv_cnt = 0;
  int err_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  always #5 clock = ~clock;

  cls_rx dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ss          (ss),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .display_on  (display_on),
    .backlight   (backlight),
    .cursor_mode (cursor_mode),
    .disp_mode   (disp_mode),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .err         (err)
  );

  always @(negedge clock) begin
    if (reset_n) begin
      if (byte_valid) begin
        bv_cnt++;
        last_byte = byte_data;
      end
      if (err) err_cnt++;
    end
  end

  typedef struct {
    logic [63:0] bytes;
    int          n;
    logic [4:0]  addr;
    logic [7:0]  data;
    logic        row;
    logic [3:0]  col;
    int          errs;
    logic [5:0]  flags;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ss = 1'b0;
    clk(4);
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = b[i];
      clk(4);
      sclk = 1'b1;
      clk(4);
    end
    clk(4);
    ss = 1'b1;
    clk(4);
  endtask

  task automatic rd(input logic [4:0] a);
    rd_addr = a;
    clk(2);
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    ss      = 1'b1;
    sclk    = 1'b1;
    mosi    = 1'b0;
    rd_addr = 5'd0;
    clk(3);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] b;
    int bv0;
    int e0;

    vt[0]  = '{64'h41,             1, 5'd0,  8'h41, 1'b0, 4'd1,  0, 6'b000000};
    vt[1]  = '{64'h42,             1, 5'd1,  8'h42, 1'b0, 4'd2,  0, 6'b000000};
    vt[2]  = '{64'h1B5B3365,       4, 5'd1,  8'h42, 1'b0, 4'd2,  0, 6'b110000};
    vt[3]  = '{64'h1B5B313B34485A, 7, 5'd20, 8'h5A, 1'b1, 4'd5,  0, 6'b110000};
    vt[4]  = '{64'h1B5B3071,       4, 5'd20, 8'h5A, 1'b1, 4'd5,  1, 6'b110000};
    vt[5]  = '{64'h1B58,           2, 5'd20, 8'h5A, 1'b1, 4'd5,  1, 6'b110000};
    vt[6]  = '{64'h41,             1, 5'd21, 8'h41, 1'b1, 4'd6,  0, 6'b110000};
    vt[7]  = '{64'h1B5B353B393948, 7, 5'd21, 8'h41, 1'b1, 4'd15, 0, 6'b110000};
    vt[8]  = '{64'h71,             1, 5'd31, 8'h71, 1'b0, 4'd0,  0, 6'b110000};
    vt[9]  = '{64'h1B5B313B323B48, 7, 5'd0,  8'h48, 1'b0, 4'd1,  1, 6'b110000};
    vt[10] = '{64'h1B5B316A,       4, 5'd0,  8'h48, 1'b0, 4'd1,  1, 6'b110000};
    vt[11] = '{64'h1B5B3130303063, 7, 5'd0,  8'h48, 1'b0, 4'd1,  0, 6'b111100};
    vt[12] = '{64'h1B5B3268,       4, 5'd0,  8'h48, 1'b0, 4'd1,  0, 6'b111110};
    vt[13] = '{64'h0A,             1, 5'd1,  8'h42, 1'b0, 4'd1,  0, 6'b111110};
    vt[14] = '{64'h1B5B3065,       4, 5'd1,  8'h42, 1'b0, 4'd1,  0, 6'b001110};
    vt[15] = '{64'h1B5B48,         3, 5'd0,  8'h48, 1'b0, 4'd0,  0, 6'b001110};

    reset_n = 1'b0;
    ss      = 1'b1;
    sclk    = 1'b1;
    mosi    = 1'b0;
    rd_addr = 5'd0;
    clk(3);
    @(negedge clock);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_cursor", 32'({cur_row, cur_col}), 32'h00);
    chk("rst_flags", 32'({display_on, backlight, cursor_mode, disp_mode}), 32'h00);
    chk("rst_byte_data", 32'(byte_data), 32'h00);
    chk("rst_pulses", 32'({byte_valid, err}), 32'h0);
    chk("rst_miso", 32'(miso), 32'h1);
    reset_n = 1'b1;
    rd(5'd5);
    chk("rst_buf", 32'(rd_data), 32'h20);

    for (int i = 0; i < 16; i++) begin
      bv0 = bv_cnt;
      e0  = err_cnt;
      b   = vt[i].bytes << (8 * (8 - vt[i].n));
      for (int k = 0; k < vt[i].n; k++) send_byte(b[63 - 8 * k -: 8]);
      clk(4);
      rd(vt[i].addr);
      chk($sformatf("v%0d_rd", i), 32'(rd_data), 32'(vt[i].data));
      chk($sformatf("v%0d_cursor", i), 32'({cur_row, cur_col}),
          32'({vt[i].row, vt[i].col}));
      chk($sformatf("v%0d_flags", i),
          32'({display_on, backlight, cursor_mode, disp_mode}),
          32'(vt[i].flags));
      chk($sformatf("v%0d_errs", i), 32'(err_cnt - e0), 32'(vt[i].errs));
      chk($sformatf("v%0d_bytes", i), 32'(bv_cnt - bv0), 32'(vt[i].n));
    end

    // Partial frame of 5 bits, then a clean byte.
    bv0 = bv_cnt;
    e0  = err_cnt;
    ss  = 1'b0;
    clk(4);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0;
      mosi = 1'b1;
      clk(4);
      sclk = 1'b1;
      clk(4);
    end
    ss = 1'b1;
    clk(8);
    chk("partial_err", 32'(err_cnt - e0), 32'd1);
    chk("partial_nobyte", 32'(bv_cnt - bv0), 32'd0);
    send_byte(8'h4B);
    clk(4);
    chk("after_partial_cnt", 32'(bv_cnt - bv0), 32'd1);
    chk("after_partial_data", 32'(last_byte), 32'h4B);
    rd(5'd0);
    chk("after_partial_buf", 32'(rd_data), 32'h4B);

    // Wrap after 32 cells, then clear.
    do_reset();
    for (int i = 0; i < 33; i++) send_byte(8'(8'h30 + i));
    clk(4);
    rd(5'd0);
    chk("wrap_addr0", 32'(rd_data), 32'h50);
    rd(5'd1);
    chk("wrap_addr1", 32'(rd_data), 32'h31);
    rd(5'd31);
    chk("wrap_addr31", 32'(rd_data), 32'h4F);
    chk("wrap_cursor", 32'({cur_row, cur_col}), 32'h01);
    e0 = err_cnt;
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h30);
    send_byte(8'h6A);
    clk(4);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      chk($sformatf("clr_addr%0d", a), 32'(rd_data), 32'h20);
    end
    chk("clr_cursor", 32'({cur_row, cur_col}), 32'h00);
    chk("clr_errs", 32'(err_cnt - e0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
